// File: rtl/neuron_sample_feeder.sv
// Training-sample buffer for the two-input perceptron: the host loads samples once,
// then they are replayed in order, epoch after epoch, over a valid/ready handshake.
module neuron_sample_feeder #(
  parameter int AW  = 6,
  parameter int EPW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           wr_en,
  input  logic [6:0]     wr_x1,
  input  logic [6:0]     wr_x2,
  input  logic [1:0]     wr_t,
  output logic           full,
  input  logic           start,
  input  logic           stop,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [6:0]     x1_out,
  output logic [6:0]     x2_out,
  output logic [1:0]     t_out,
  output logic [19:0]    n_out,
  output logic           epoch_done,
  output logic [EPW-1:0] epoch_count,
  output logic           busy,
  output logic [1:0]     dbg_state_o
);

  // Handshake: a sample moves on every rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low the presented sample is held unchanged.

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PLAY = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [AW:0]    DEPTH_C  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]    CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]  PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [EPW-1:0] EP_ONE   = {{(EPW-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [AW:0]    count_q, count_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [EPW-1:0] epoch_count_q, epoch_count_d;
  logic           epoch_done_q, epoch_done_d;
  logic           mem_we;

  logic [15:0]    mem [0:(1<<AW)-1];
  logic [15:0]    rd_word;
  logic           last_c;
  logic           xfer_c;

  assign rd_word = mem[rd_ptr_q];
  assign last_c  = ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
  assign xfer_c  = out_valid && out_ready;

  assign full        = (count_q == DEPTH_C);
  assign n_out       = {{(20-AW-1){1'b0}}, count_q};
  assign out_valid   = (state_q == ST_PLAY);
  assign busy        = (state_q == ST_PLAY);
  assign x1_out      = out_valid ? rd_word[15:9] : 7'd0;
  assign x2_out      = out_valid ? rd_word[8:2]  : 7'd0;
  assign t_out       = out_valid ? rd_word[1:0]  : 2'd0;
  assign epoch_done  = epoch_done_q;
  assign epoch_count = epoch_count_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    epoch_count_d = epoch_count_q;
    epoch_done_d  = 1'b0;
    mem_we        = 1'b0;
    if (clear) begin
      // A handshake in this cycle is discarded, wrap included.
      state_d       = ST_LOAD;
      count_d       = '0;
      rd_ptr_d      = '0;
      epoch_count_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (start && (count_q != '0)) begin
            state_d       = ST_PLAY;
            rd_ptr_d      = '0;
            epoch_count_d = '0;
          end else if (wr_en && !full) begin
            mem_we  = 1'b1;
            count_d = count_q + CNT_ONE;
          end
        end
        ST_PLAY: begin
          if (xfer_c) begin
            if (last_c) begin
              rd_ptr_d     = '0;
              epoch_done_d = 1'b1;
              if (!(&epoch_count_q)) epoch_count_d = epoch_count_q + EP_ONE;
            end else begin
              rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
          end
          if (stop) state_d = ST_HALT;
        end
        ST_HALT: begin
          if (start) begin
            state_d       = ST_PLAY;
            rd_ptr_d      = '0;
            epoch_count_d = '0;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      epoch_count_q <= '0;
      epoch_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      epoch_count_q <= epoch_count_d;
      epoch_done_q  <= epoch_done_d;
    end
  end

  // Sample storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[count_q[AW-1:0]] <= {wr_x1, wr_x2, wr_t};
  end

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Bench for neuron_sample_feeder: a reference sample store feeds an expected queue,
// and every accepted handshake is popped and compared.
module tb_neuron_sample_feeder;

  logic        clk = 1'b0;
  logic        rst, clear, wr_en, start, stop, out_ready;
  logic [6:0]  wr_x1, wr_x2;
  logic [1:0]  wr_t;
  logic        full, out_valid, epoch_done, busy;
  logic [6:0]  x1_out, x2_out;
  logic [1:0]  t_out;
  logic [19:0] n_out;
  logic [15:0] epoch_count;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_mem[64];
  int          m_n = 0;

  neuron_sample_feeder #(.AW(6), .EPW(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en),
    .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t), .full(full),
    .start(start), .stop(stop), .out_valid(out_valid), .out_ready(out_ready),
    .x1_out(x1_out), .x2_out(x2_out), .t_out(t_out), .n_out(n_out),
    .epoch_done(epoch_done), .epoch_count(epoch_count), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sample(input logic [6:0] a, input logic [6:0] b, input logic [1:0] t);
    wr_en = 1'b1; wr_x1 = a; wr_x2 = b; wr_t = t;
    tick();
    wr_en = 1'b0;
    if (m_n < 64) begin
      m_mem[m_n] = {a, b, t};
      m_n++;
    end
  endtask

  task automatic push_play(input int first, input int num);
    for (int k = 0; k < num; k++) exp_q.push_back(m_mem[(first + k) % m_n]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_x1"}, x1_out, 0);
    check({tag, "_t"}, t_out, 0);
  endtask

  // Scoreboard: each accepted handshake pops one expected sample.
  always @(negedge clk) begin
    if (!rst && !clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_xfer", 1, 0);
      else check("sample", {x1_out, x2_out, t_out}, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    wr_x1 = '0; wr_x2 = '0; wr_t = '0;
    tick(); tick();
    rst = 1'b0;
    check_idle("reset");
    check("reset_full", full, 0);
    check("reset_n", n_out, 0);
    check("reset_epoch_count", epoch_count, 0);
    check("reset_epoch_done", epoch_done, 0);
    check("reset_state", dbg_state, 0);

    // Three samples, continuous ready: three epochs back to back.
    write_sample(7'd3, 7'd5, 2'd1);
    write_sample(7'd10, 7'd2, 2'd3);
    write_sample(7'd7, 7'd7, 2'd0);
    check("n_three", n_out, 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_in_load", dbg_state, 0);
    push_play(0, 9);
    out_ready = 1'b1;
    pulse_start();
    check("play_valid", out_valid, 1);
    check("play_busy", busy, 1);
    for (int j = 1; j <= 9; j++) begin
      tick();
      check("cont_epoch_done", epoch_done, (j % 3) == 0);
      check("cont_epoch_count", epoch_count, j / 3);
    end
    out_ready = 1'b0;
    check("hold_x1", x1_out, m_mem[0][15:9]);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("halt");
    check("halt_epoch_hold", epoch_count, 3);

    // Toggled ready: epoch_done every six cycles.
    push_play(0, 6);
    pulse_start();
    check("restart_epoch_count", epoch_count, 0);
    for (int c = 0; c < 12; c++) begin
      out_ready = (c % 2) == 0;
      tick();
      check("toggle_epoch_done", epoch_done, ((c % 2) == 0) && (((c / 2 + 1) % 3) == 0));
    end
    out_ready = 1'b0;

    // Stop together with a transfer at rd_ptr=1.
    push_play(0, 2);
    out_ready = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0; out_ready = 1'b0;
    check_idle("stop_xfer");
    check("stop_xfer_state", dbg_state, 2);
    check("stop_xfer_epoch", epoch_count, 2);
    pulse_start();
    check("replay_epoch_count", epoch_count, 0);
    check("replay_first_x1", x1_out, m_mem[0][15:9]);
    check("replay_first_x2", x2_out, m_mem[0][8:2]);
    push_play(0, 2);
    out_ready = 1'b1;
    tick();
    tick();

    // Clear during a wrapping handshake: discarded, no epoch_done.
    clear = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    m_n = 0;
    check_idle("clear");
    check("clear_n", n_out, 0);
    check("clear_epoch_count", epoch_count, 0);
    check("clear_epoch_done", epoch_done, 0);
    check("clear_state", dbg_state, 0);
    tick();
    check("clear_epoch_done_late", epoch_done, 0);

    pulse_start();
    check_idle("empty_start");
    check("empty_start_state", dbg_state, 0);

    // Single sample: every transfer wraps.
    write_sample(7'd21, 7'd42, 2'd2);
    push_play(0, 4);
    out_ready = 1'b1;
    pulse_start();
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("single_epoch_done", epoch_done, 1);
      check("single_epoch_count", epoch_count, j);
    end
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_n = 0;

    // Fill past capacity; the 65th write is dropped.
    for (int i = 0; i <= 64; i++) begin
      logic [6:0] v;
      v = 7'(i);
      write_sample(v, v ^ 7'h55, v[1:0]);
      if (i == 62) check("not_full_63", full, 0);
      if (i == 63) check("full_64", full, 1);
    end
    check("full_n", n_out, 64);
    check("full_after_drop", full, 1);
    push_play(0, 65);
    out_ready = 1'b1;
    pulse_start();
    for (int j = 1; j <= 65; j++) begin
      tick();
      if (j == 63 || j == 64 || j == 65) check("big_epoch_done", epoch_done, j == 64);
    end
    check("big_epoch_count", epoch_count, 1);

    // Reset mid-PLAY with ready high.
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check_idle("rst_mid");
    check("rst_mid_n", n_out, 0);
    check("rst_mid_epoch_count", epoch_count, 0);
    check("rst_mid_epoch_done", epoch_done, 0);
    check("rst_mid_full", full, 0);
    tick();
    check("rst_mid_epoch_done_late", epoch_done, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
